// File: rtl/cpu_beat_sequencer_if.sv
// cpu_beat_sequencer_if: handshake, instruction-flag and phase/beat bundle of the beat sequencer
interface cpu_beat_sequencer_if #(parameter int CNT_W = 32);
  logic halt, done_in;
  logic ins_ADD, ins_SUB, ins_SW, ins_LW, ins_ADDI, ins_LUI, ins_JAL;
  logic Mif, Mex, T1, T2, T3, T4;
  logic retire, ill_ins, halted, bus_timeout;
  logic [CNT_W-1:0] instr_cnt;
  modport master (
    output halt, done_in, ins_ADD, ins_SUB, ins_SW, ins_LW, ins_ADDI, ins_LUI, ins_JAL,
    input Mif, Mex, T1, T2, T3, T4, retire, ill_ins, halted, bus_timeout, instr_cnt
  );
  modport slave (
    input halt, done_in, ins_ADD, ins_SUB, ins_SW, ins_LW, ins_ADDI, ins_LUI, ins_JAL,
    output Mif, Mex, T1, T2, T3, T4, retire, ill_ins, halted, bus_timeout, instr_cnt
  );
endinterface

// File: rtl/cpu_beat_sequencer.sv
// cpu_beat_sequencer: Mif/Mex phase and T-beat generator with halt, watchdog and retire counting
module cpu_beat_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  cpu_beat_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IF_T1, IF_T2, EX_T1, EX_T2, EX_T3, FAULT} state_t;
  state_t state, next;
  logic [15:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic timeout;
  logic mem, alu, wait_beat, expire, fin;
  assign mem = bus.ins_SW | bus.ins_LW;
  assign alu = bus.ins_ADD | bus.ins_SUB | bus.ins_ADDI | bus.ins_LUI | bus.ins_JAL;
  assign wait_beat = state == IF_T2 || state == EX_T3;
  assign expire = wait_beat && !bus.done_in && wcnt == 16'(TIMEOUT_CYCLES - 1);
  // MEM instructions ignore done in EX_T1; only ALU/ILL finish there
  assign fin = bus.done_in && (state == EX_T3 || (state == EX_T1 && !mem));
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = bus.halt ? IDLE : IF_T1;
      IF_T1:   next = IF_T2;
      IF_T2:   next = bus.done_in ? EX_T1 : expire ? FAULT : IF_T2;
      EX_T1:   next = mem ? EX_T2 : fin ? (bus.halt ? IDLE : IF_T1) : EX_T1;
      EX_T2:   next = EX_T3;
      EX_T3:   next = fin ? (bus.halt ? IDLE : IF_T1) : expire ? FAULT : EX_T3;
      default: next = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      timeout <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= next;
      wcnt    <= (wait_beat && next == state) ? wcnt + 16'd1 : 16'd0;
      timeout <= timeout | expire;
      cnt     <= cnt + CNT_W'(fin);
    end
  end
  assign bus.Mif = state == IF_T1 || state == IF_T2;
  assign bus.Mex = state == EX_T1 || state == EX_T2 || state == EX_T3;
  assign bus.T1 = state == IF_T1 || state == EX_T1;
  assign bus.T2 = state == IF_T2 || state == EX_T2;
  assign bus.T3 = state == EX_T3;
  assign bus.T4 = 1'b0;
  assign bus.retire = fin;
  assign bus.ill_ins = state == EX_T1 && !mem && !alu;
  assign bus.halted = state == IDLE || state == FAULT;
  assign bus.bus_timeout = timeout;
  assign bus.instr_cnt = cnt;
endmodule
